// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the ROM address/data pair, the branch redirect request and
// the decode-facing valid/ready instruction channel, plus the sticky fault flag.
interface fetch_unit_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational ROM and buffers
// {pc, instr} pairs in a small FIFO toward decode, with redirect and fault stop.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          MEM_SIZE   = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [16:0]      MEM_LIMIT = 17'(MEM_SIZE);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_RUN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  state_t           state;
  logic             fault_q;
  logic [15:0]      pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  entry_t           fifo_mem [FIFO_DEPTH];

  logic [16:0] pc_end;
  logic [16:0] target_end;
  logic        pc_bad;
  logic        target_bad;
  logic        full;
  logic        pop;
  logic        push;

  // Last byte of the 4-byte fetch window, kept 17 bits wide so it never wraps.
  assign pc_end     = {1'b0, pc} + 17'd3;
  assign target_end = {1'b0, bus.redirect_pc} + 17'd3;
  assign pc_bad     = (pc[1:0] != 2'b00) || (pc_end >= MEM_LIMIT);
  assign target_bad = (bus.redirect_pc[1:0] != 2'b00) || (target_end >= MEM_LIMIT);

  assign full = (count == DEPTH_C);
  assign pop  = (count != '0) && bus.out_ready;
  assign push = (state == S_RUN) && !bus.redirect_valid && !pc_bad && (!full || pop);

  assign bus.imem_addr = pc;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      fault_q <= 1'b0;
      pc      <= RESET_PC;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect flushes the buffer; a transfer in this cycle still completed.
      pc     <= bus.redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (target_bad) begin
        state   <= S_FAULT;
        fault_q <= 1'b1;
      end else begin
        state   <= S_RUN;
        fault_q <= 1'b0;
      end
    end else begin
      if (push) begin
        pc     <= pc + 16'd4;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      case (state)
        S_RUN: begin
          if (pc_bad) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end
        end
        S_FAULT: begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end
        default: begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the buffer storage has no reset; count alone decides which entries
  // are live, so clearing the data would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: pc, instr: bus.imem_instr};
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.fault     = fault_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.out_pc    = 16'h0000;
    bus.out_instr = 16'h0000;
    if (count != '0) begin
      bus.out_pc    = fifo_mem[rd_ptr].pc;
      bus.out_instr = fifo_mem[rd_ptr].instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, a throughput
// sequence, and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam int          MEM_SIZE   = 1024;
  localparam int          FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_SIZE  (MEM_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return {a[15:2], 2'b11};
  endfunction

  assign bus.imem_instr = rom(bus.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of fetched {pc, instr} ----------
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_fault;
  bit          use_model = 1'b0;

  function automatic bit addr_bad(input logic [15:0] a);
    return (a[1:0] != 2'b00) || (int'(a) + 3 >= MEM_SIZE);
  endfunction

  task automatic model_update(input bit rst, input bit rdy, input bit rv, input logic [15:0] rpc);
    if (rst) begin
      q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else begin
      if (q.size() > 0 && rdy) q.delete(0);
      if (rv) begin
        q.delete();
        m_pc    = rpc;
        m_fault = addr_bad(rpc);
      end else if (!m_fault) begin
        if (addr_bad(m_pc)) begin
          m_fault = 1'b1;
        end else if (q.size() < FIFO_DEPTH) begin
          q.push_back('{m_pc, rom(m_pc)});
          m_pc = m_pc + 16'd4;
        end
      end
    end
  endtask

  task automatic model_compare();
    logic        ev;
    logic [15:0] epc, ein;
    ev  = (q.size() > 0);
    epc = ev ? q[0].pc : 16'h0000;
    ein = ev ? q[0].instr : 16'h0000;
    check("rnd.out_valid", 16'(bus.out_valid), 16'(ev));
    check("rnd.out_pc", bus.out_pc, epc);
    check("rnd.out_instr", bus.out_instr, ein);
    check("rnd.fault", 16'(bus.fault), 16'(m_fault));
    check("rnd.imem_addr", bus.imem_addr, m_pc);
  endtask

  // One clock: drive inputs, let the edge happen, sample on the falling edge.
  task automatic step(input bit rst, input bit rdy, input bit rv, input logic [15:0] rpc);
    reset              = rst;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    model_update(rst, rdy, rv, rpc);
    @(negedge clk);
    if (use_model) model_compare();
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [15:0] rpc;
    bit          e_valid;
    logic [15:0] e_pc;
    bit          e_fault;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit rst, input bit rdy, input bit rv, input logic [15:0] rpc,
                     input bit ev, input logic [15:0] epc, input bit ef, input logic [15:0] ea);
    vt.push_back('{rst, rdy, rv, rpc, ev, epc, ef, ea});
  endtask

  initial begin
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;

    // Reset state, then streaming from RESET_PC.
    add(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0008);
    add(0, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'h000C);
    // Stall five cycles: FIFO fills, PC stalls at 0x0008.
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h000C);
    add(0, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'h0010);
    add(0, 1, 0, 16'h0000, 1, 16'h000C, 0, 16'h0014);
    // Redirect with full FIFO and a transfer in the same cycle.
    add(0, 1, 1, 16'h0100, 0, 16'h0000, 0, 16'h0100);
    add(0, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0104);
    // Misaligned redirect faults; a good redirect recovers.
    add(0, 1, 1, 16'h0102, 0, 16'h0000, 1, 16'h0102);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102);
    add(0, 1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0040);
    add(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0044);
    // Run off the end of memory.
    add(0, 1, 1, 16'h03F8, 0, 16'h0000, 0, 16'h03F8);
    add(0, 1, 0, 16'h0000, 1, 16'h03F8, 0, 16'h03FC);
    add(0, 1, 0, 16'h0000, 1, 16'h03FC, 0, 16'h0400);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400);
    // Full FIFO plus fault, then reset.
    add(0, 0, 1, 16'h03F8, 0, 16'h0000, 0, 16'h03F8);
    add(0, 0, 0, 16'h0000, 1, 16'h03F8, 0, 16'h03FC);
    add(0, 0, 0, 16'h0000, 1, 16'h03F8, 0, 16'h0400);
    add(0, 0, 0, 16'h0000, 1, 16'h03F8, 1, 16'h0400);
    add(0, 0, 0, 16'h0000, 1, 16'h03F8, 1, 16'h0400);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0008);
    // Range boundary: 0x0400 is out of range, 0x03FC is the last good word.
    add(0, 1, 1, 16'h0400, 0, 16'h0000, 1, 16'h0400);
    add(0, 1, 1, 16'h03FC, 0, 16'h0000, 0, 16'h03FC);
    add(0, 1, 0, 16'h0000, 1, 16'h03FC, 0, 16'h0400);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].rv, vt[i].rpc);
      check($sformatf("vec%0d.out_valid", i), 16'(bus.out_valid), 16'(vt[i].e_valid));
      check($sformatf("vec%0d.out_pc", i), bus.out_pc, vt[i].e_pc);
      check($sformatf("vec%0d.out_instr", i), bus.out_instr,
            vt[i].e_valid ? rom(vt[i].e_pc) : 16'h0000);
      check($sformatf("vec%0d.fault", i), 16'(bus.fault), 16'(vt[i].e_fault));
      check($sformatf("vec%0d.imem_addr", i), bus.imem_addr, vt[i].e_addr);
    end

    // Sustained throughput: one instruction per cycle, no gaps.
    step(1, 1, 0, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 16'h0000);
      check($sformatf("thru%0d.out_valid", i), 16'(bus.out_valid), 16'h0001);
      check($sformatf("thru%0d.out_pc", i), bus.out_pc, 16'(i * 4));
    end

    // Randomized traffic against the reference model.
    step(1, 0, 0, 16'h0000);
    use_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit          r_rst, r_rdy, r_rv;
      logic [15:0] r_pc;
      r_rst = ($urandom_range(0, 499) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       r_pc = 16'($urandom_range(0, 65535));
        1:       r_pc = 16'h03F0 + 16'($urandom_range(0, 15));
        default: r_pc = 16'($urandom_range(0, 255)) << 2;
      endcase
      step(r_rst, r_rdy, r_rv, r_pc);
    end
    use_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational 16-bit instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned instruction together with its PC into a small FIFO.
- Presents fetched instructions to decode over a valid/ready handshake, with branch redirect and address-fault detection.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset; must be 4-byte aligned
MEM_SIZE, 1024, instruction memory size in bytes; power of two, > 4
FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  16  byte address to instruction ROM; equals current PC
imem_instr  in  16  ROM data for imem_addr, valid same cycle (combinational ROM)
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  16  redirect target byte address
out_valid  out  1  fetch buffer head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  16  head instruction; 16'h0000 when out_valid=0
out_pc  out  16  head instruction PC; 16'h0000 when out_valid=0
fault  out  1  sticky: fetch stopped on misaligned or out-of-range PC

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, FIFO count=0, state=RUN. Outputs: out_valid=0, fault=0, imem_addr=RESET_PC, out_instr/out_pc=0. Reset mid-operation discards all FIFO contents and fault state.
- States:
  - RUN: fetching normally.
  - FAULT: PC frozen, no pushes, FIFO may still drain; fault=1.
- imem_addr = pc combinationally, in both states.
- pc_bad = (pc[1:0] != 0) OR (pc + 3 >= MEM_SIZE). Compute the sum 17 bits wide; no wrap.
- Transfer: out_valid & out_ready at a rising edge pops the head.
- Push condition: state=RUN, no redirect, pc_bad=0, and (count < FIFO_DEPTH, or count==FIFO_DEPTH with a pop the same cycle).
  - On push: {pc, imem_instr} is written to the tail and pc <= pc + 4.
  - Simultaneous push+pop keeps count unchanged.
- RUN with pc_bad=1 and no redirect: no push; state <= FAULT; pc holds.
- Redirect (redirect_valid=1, highest priority, either state):
  - A transfer presented in the same cycle still completes; decode owns squashing it.
  - The FIFO is flushed (count <= 0) and the ROM data this cycle is discarded.
  - pc <= redirect_pc.
  - If redirect_pc[1:0] != 0 or redirect_pc + 3 >= MEM_SIZE: state <= FAULT. Otherwise state <= RUN and fault clears.
- Latency:
  - A pushed instruction appears at the head (out_valid=1) the cycle after its push edge if the FIFO was empty.
  - After a redirect, the first target instruction is visible 2 cycles after the redirect edge: fetch in cycle +1, out_valid in cycle +2.
  - Sustained throughput is 1 instruction/cycle with out_ready held high.
- Full FIFO with out_ready=0: pc and imem_addr hold and no entry is overwritten.
- Empty FIFO: out_valid=0, and out_ready is ignored.
- Ordering: strictly in PC-fetch order; no drop or duplicate except by redirect flush.
- fault, out_valid, out_instr and out_pc are driven from registers only. No combinational path from out_ready or redirect_* to any output.

Test Plan:
- Reset, ROM returns instr = {pc[15:2], 2'b11}, out_ready=1 -> out_valid rises 1 cycle after reset drops; out_pc sequence 0x0000, 0x0004, 0x0008... one per cycle with matching out_instr.
- out_ready=0 for 5 cycles from start -> imem_addr stalls at 0x0008 with count=2 and out_pc holds 0x0000. Release -> out_pc 0x0000, 0x0004, 0x0008 back-to-back, no gaps or duplicates.
- FIFO full, redirect_valid=1 with redirect_pc=0x0100 and out_ready=1 -> head pc 0x0000 accepted that cycle. Next cycle out_valid=0 and imem_addr=0x0100; following cycle out_pc=0x0100.
- Redirect to 0x0102 -> next cycle fault=1, out_valid=0, imem_addr=0x0102 held. Then redirect to 0x0040 -> fault=0, and out_pc=0x0040 two cycles later.
- Redirect to 0x03F8, out_ready=1 -> out_pc 0x03F8, 0x03FC delivered, then fault=1 with imem_addr held at 0x0400 and out_valid=0 after drain.
- FIFO full and fault=1, assert reset one cycle -> next cycle out_valid=0, fault=0, imem_addr=RESET_PC; normal fetch resumes from 0x0000.
